// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl: double-buffer swap sequencer; clears buffers, gates rendering, swaps on vblank rising edge.
module fb_swap_ctrl #(
  parameter int FRAME_CNT_WIDTH = 16,
  parameter bit INIT_CLEAR_BOTH = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       render_done,
  input  logic                       vblank,
  input  logic [1:0]                 fb_clearing,
  output logic [1:0]                 fb_clear,
  output logic                       front_sel,
  output logic                       back_sel,
  output logic                       render_start,
  output logic                       busy_clear,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic [FRAME_CNT_WIDTH-1:0] late_frames
);
  typedef enum logic [2:0] {
    INIT_REQ, INIT_ARM, INIT_WAIT, CLR_REQ, CLR_ARM, CLR_WAIT, RENDER, WAIT_VBL
  } state_t;
  localparam state_t RST_STATE = INIT_CLEAR_BOTH ? INIT_REQ : CLR_REQ;
  state_t state, state_nx;
  logic vblank_q;
  logic vbl_rise;
  logic front_clearing;
  logic back_clearing;
  assign vbl_rise       = vblank & ~vblank_q;
  assign back_sel       = ~front_sel;
  assign front_clearing = fb_clearing[front_sel];
  assign back_clearing  = fb_clearing[back_sel];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RST_STATE;
    else     state <= state_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblank_q    <= 1'b0;
      front_sel   <= 1'b0;
      frame_count <= '0;
      late_frames <= '0;
    end else begin
      vblank_q <= vblank;
      if (state == WAIT_VBL && vbl_rise) begin
        front_sel   <= ~front_sel;
        frame_count <= frame_count + 1'b1;
      end
      if (state == RENDER && vbl_rise && !render_done && late_frames != '1)
        late_frames <= late_frames + 1'b1;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      INIT_REQ:  state_nx = INIT_ARM;
      INIT_ARM:  state_nx = front_clearing ? INIT_WAIT : INIT_ARM;
      INIT_WAIT: state_nx = front_clearing ? INIT_WAIT : CLR_REQ;
      CLR_REQ:   state_nx = CLR_ARM;
      CLR_ARM:   state_nx = back_clearing ? CLR_WAIT : CLR_ARM;
      CLR_WAIT:  state_nx = back_clearing ? CLR_WAIT : RENDER;
      RENDER:    state_nx = render_done ? WAIT_VBL : RENDER;
      WAIT_VBL:  state_nx = vbl_rise ? CLR_REQ : WAIT_VBL;
      default:   state_nx = RST_STATE;
    endcase
  end
  // Clear requests are Mealy on rst so nothing leaks out while reset holds the FSM in a request state.
  always_comb begin
    fb_clear     = rst                 ? 2'b00 :
                   state == INIT_REQ   ? (front_sel ? 2'b10 : 2'b01) :
                   state == CLR_REQ    ? (back_sel  ? 2'b10 : 2'b01) : 2'b00;
    render_start = state == CLR_WAIT && !back_clearing;
    busy_clear   = state != RENDER && state != WAIT_VBL;
  end
endmodule

// File: tb/tb_fb_swap_ctrl.sv
// tb_fb_swap_ctrl: scoreboard bench; expected clear/start/swap events are queued with stimulus and matched by a monitor.
module tb_fb_swap_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        render_done = 1'b0;
  logic        vblank = 1'b0;
  logic [1:0]  fb_clearing;
  logic [1:0]  fb_clear;
  logic        front_sel, back_sel, render_start, busy_clear;
  logic [15:0] frame_count, late_frames;
  int total = 0;
  int bad = 0;
  logic [31:0] q[$];
  logic [2:0] cnt0 = 3'd0;
  logic [2:0] cnt1 = 3'd0;
  logic prev_front = 1'b0;
  logic prev_clear = 1'b0;

  fb_swap_ctrl dut (
    .clk(clk), .rst(rst), .render_done(render_done), .vblank(vblank),
    .fb_clearing(fb_clearing), .fb_clear(fb_clear), .front_sel(front_sel),
    .back_sel(back_sel), .render_start(render_start), .busy_clear(busy_clear),
    .frame_count(frame_count), .late_frames(late_frames)
  );

  always #5 clk = ~clk;

  // Framebuffer model: busy for 4 cycles after each clear request.
  always @(posedge clk) begin
    cnt0 <= fb_clear[0] ? 3'd4 : (cnt0 != 0 ? cnt0 - 3'd1 : 3'd0);
    cnt1 <= fb_clear[1] ? 3'd4 : (cnt1 != 0 ? cnt1 - 3'd1 : 3'd0);
  end
  assign fb_clearing = {cnt1 != 0, cnt0 != 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_ev(input string tag, input logic [31:0] got);
    if (q.size() == 0) chk(tag, got, 32'hdead_beef);
    else chk(tag, got, q.pop_front());
  endtask

  function automatic logic [31:0] ev_clr(input logic [1:0] v);
    return {8'd1, 22'd0, v};
  endfunction
  function automatic logic [31:0] ev_start();
    return {8'd2, 24'd0};
  endfunction
  function automatic logic [31:0] ev_swap(input logic f, input logic [15:0] c);
    return {8'd3, 7'd0, f, c};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (front_sel != prev_front) expect_ev("swap", {8'd3, 7'd0, front_sel, frame_count});
      if (fb_clear != 2'b00) begin
        chk("clr_onehot", {31'd0, $onehot(fb_clear)}, 32'd1);
        chk("clr_gap", {31'd0, prev_clear}, 32'd0);
        expect_ev("clear", {8'd1, 22'd0, fb_clear});
      end
      if (render_start) expect_ev("start", {8'd2, 24'd0});
    end
    prev_front = front_sel;
    prev_clear = fb_clear != 2'b00;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, q.size(), 0);
    q.delete();
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_front", {31'd0, front_sel}, 32'd0);
    chk("rst_back", {31'd0, back_sel}, 32'd1);
    chk("rst_clear", {30'd0, fb_clear}, 32'd0);
    chk("rst_start", {31'd0, render_start}, 32'd0);
    chk("rst_fcnt", {16'd0, frame_count}, 32'd0);
    chk("rst_late", {16'd0, late_frames}, 32'd0);
    q.push_back(ev_clr(2'b01));
    q.push_back(ev_clr(2'b10));
    q.push_back(ev_start());
    rst = 1'b0;
    wait_empty("init_seq");
    chk("init_front", {31'd0, front_sel}, 32'd0);
    chk("render_idle", {31'd0, busy_clear}, 32'd0);
    // Normal frame: render_done at T, vblank rise at T+10.
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
    repeat (9) tick();
    chk("pre_swap_front", {31'd0, front_sel}, 32'd0);
    q.push_back(ev_swap(1'b1, 16'd1));
    q.push_back(ev_clr(2'b01));
    q.push_back(ev_start());
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    chk("swap_front", {31'd0, front_sel}, 32'd1);
    chk("swap_back", {31'd0, back_sel}, 32'd0);
    chk("swap_fcnt", {16'd0, frame_count}, 32'd1);
    chk("swap_clear", {30'd0, fb_clear}, 32'd1);
    wait_empty("swap_seq");
    // Late frames: three vblank rises while still rendering.
    for (int i = 0; i < 3; i++) begin
      vblank = 1'b1;
      tick();
      vblank = 1'b0;
      repeat (2) tick();
    end
    chk("late3", {16'd0, late_frames}, 32'd3);
    chk("late3_front", {31'd0, front_sel}, 32'd1);
    // render_done coincident with vblank rise: no late count, no swap yet.
    render_done = 1'b1;
    vblank = 1'b1;
    tick();
    render_done = 1'b0;
    chk("coinc_late", {16'd0, late_frames}, 32'd3);
    repeat (4) tick();
    chk("coinc_noswap", {31'd0, front_sel}, 32'd1);
    vblank = 1'b0;
    tick();
    q.push_back(ev_swap(1'b0, 16'd2));
    q.push_back(ev_clr(2'b10));
    q.push_back(ev_start());
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    chk("coinc_front", {31'd0, front_sel}, 32'd0);
    chk("coinc_fcnt", {16'd0, frame_count}, 32'd2);
    wait_empty("coinc_seq");
    // WAIT_VBL entered with vblank already high.
    vblank = 1'b1;
    tick();
    repeat (2) tick();
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
    repeat (5) tick();
    chk("held_noswap", {31'd0, front_sel}, 32'd0);
    chk("held_late", {16'd0, late_frames}, 32'd4);
    vblank = 1'b0;
    tick();
    q.push_back(ev_swap(1'b1, 16'd3));
    q.push_back(ev_clr(2'b01));
    q.push_back(ev_start());
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    chk("held_front", {31'd0, front_sel}, 32'd1);
    wait_empty("held_seq");
    // Reset in the middle of CLR_WAIT.
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
    q.push_back(ev_swap(1'b0, 16'd4));
    q.push_back(ev_clr(2'b10));
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    for (int n = 0; n < 50 && !fb_clearing[1]; n++) tick();
    tick();
    chk("midclr_busy", {31'd0, busy_clear}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_fcnt", {16'd0, frame_count}, 32'd0);
    chk("mid_rst_late", {16'd0, late_frames}, 32'd0);
    chk("mid_rst_front", {31'd0, front_sel}, 32'd0);
    chk("mid_rst_back", {31'd0, back_sel}, 32'd1);
    chk("mid_rst_clear", {30'd0, fb_clear}, 32'd0);
    chk("mid_rst_start", {31'd0, render_start}, 32'd0);
    chk("mid_rst_queue", q.size(), 0);
    q.delete();
    tick();
    q.push_back(ev_clr(2'b01));
    q.push_back(ev_clr(2'b10));
    q.push_back(ev_start());
    rst = 1'b0;
    wait_empty("restart_seq");
    chk("restart_front", {31'd0, front_sel}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
